digit_entry_display: RTL
========================

# digit_entry_display

Two-digit decimal entry buffer and seven-segment driver for the calculator front end. Consumes the single-cycle data-valid pulses produced by the button/debounce layer, each carrying a 4-bit key code. Shifts accepted decimal digits into a two-digit register and drives both seven-segment digits directly, with the segments active-low. Reports the entered value in binary and flags overflow by blinking the display until it is cleared.

## Interface
- BLINK_TIME, 12500000, cycles per blink half-period in OVERFLOW (0.5 s at 25 MHz); range 1 to 2^24-1
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_DV  in  1  one-cycle pulse: i_digit valid this cycle
- i_digit  in  4  key code; 0-9 are digits, 10-15 are invalid
- i_clear  in  1  synchronous clear, level-sampled each cycle
- o_seg_tens  out  7  tens digit segments, active-low, bit0=a … bit6=g
- o_seg_ones  out  7  ones digit segments, same encoding
- o_value  out  7  binary value tens*10+ones, range 0-99
- o_count  out  2  number of digits held, 0-2
- o_overflow  out  1  high while in OVERFLOW

## Operation
- States:
  - EMPTY: count 0, both digits blank.
  - ONE: count 1, ones = d0, tens blank.
  - TWO: count 2, tens = d1, ones = d0.
  - OVERFLOW: digits frozen, display blinks.
- An accepted event is a cycle where i_DV=1, i_digit≤9 and i_clear=0. Invalid codes (10-15) are ignored with no state or register change.
- Transitions on an accepted digit d:
  - EMPTY → ONE: ones=d.
  - ONE with ones=0 → stays ONE: ones=d (replaces the leading zero).
  - ONE with ones≠0 → TWO: tens=ones, ones=d.
  - TWO → OVERFLOW: digits unchanged, digit d discarded.
  - OVERFLOW: digits ignored.
- i_clear=1 → EMPTY from any state. Tens, ones and the blink counter are zeroed. Clear wins over a simultaneous i_DV.
- Segment encoding (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- Blink in OVERFLOW:
  - A 24-bit counter is zeroed on entry and counts 0..BLINK_TIME-1, then wraps and toggles the phase.
  - Phase "on" first: both digits shown. Phase "off": both digits 7F.
  - The counter is idle and held at 0 outside OVERFLOW.
- o_value is tens*10+ones, computed as (tens<<3)+(tens<<1)+ones at 7-bit width. It is 0 in EMPTY and keeps its frozen value in OVERFLOW.
- Reset values of all outputs: o_seg_tens=7F, o_seg_ones=7F, o_value=0, o_count=0, o_overflow=0. Internally: state EMPTY, tens=ones=0, blink counter 0, phase on.

## Timing
- Reset is asserted asynchronously: all registers and outputs reach their reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally to clk.
- The i_DV/i_clear sample at edge N updates state, digits, o_count and o_overflow at edge N.
- o_seg_*, o_value: registered from the post-edge state, so they are valid after edge N+1 (one cycle of display latency).
- Back-to-back i_DV pulses on consecutive cycles are each accepted. There is no busy or backpressure signal.
- Blink timing: entry to OVERFLOW at edge N. The first blank phase is displayed after edge N+1+BLINK_TIME. Each phase lasts exactly BLINK_TIME cycles.
- Reset asserted mid-OVERFLOW or mid-entry: the block returns to EMPTY. The first i_DV after release is treated as a first digit.

## Test plan
- Reset, then i_DV with digit 4, then digit 7 (consecutive cycles) → o_count 1 then 2. One cycle later: o_seg_tens=19, o_seg_ones=78, o_value=47.
- From EMPTY, enter 0 then 5 → stays ONE, o_seg_tens=7F, o_seg_ones=12, o_value=5. Then i_DV with i_digit=12 → no change.
- With BLINK_TIME=4: enter 9, 9, 3 → o_overflow=1, o_value=99. Segments show 10/10 for 4 cycles, then 7F/7F for 4 cycles, alternating. A further digit 2 has no effect.
- In TWO (value 47), assert i_clear and i_DV (digit 1) on the same cycle → EMPTY, o_count=0, o_value=0, both segments 7F on the following cycle.
- Assert rst_n=0 asynchronously between edges during an OVERFLOW blank phase → outputs read 7F/7F, 0, 0, 0 before the next edge. After release, digit 8 → o_seg_ones=00, o_count=1.

Source files
------------

// File: rtl/digit_entry_display.sv
// Two-digit decimal entry buffer with active-low seven-segment drive, binary value output
// and a blinking overflow indication.
module digit_entry_display #(
    parameter int unsigned BLINK_TIME = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_DV,
    input  logic [3:0] i_digit,
    input  logic       i_clear,
    output logic [6:0] o_seg_tens,
    output logic [6:0] o_seg_ones,
    output logic [6:0] o_value,
    output logic [1:0] o_count,
    output logic       o_overflow
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo, StOverflow} state_e;

    localparam logic [23:0] BlinkLast = 24'(BLINK_TIME - 1);
    localparam logic [6:0]  SegBlank  = 7'h7F;

    state_e      state_q;
    logic [3:0]  tens_q, ones_q;
    logic [23:0] blink_cnt_q;
    logic        phase_off_q;
    logic [6:0]  seg_tens_q, seg_ones_q, value_q;

    logic       accept;
    logic       blank_all, blank_tens;
    logic [6:0] tens7, ones7, value_d;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'h40;
            4'd1:    seg_enc = 7'h79;
            4'd2:    seg_enc = 7'h24;
            4'd3:    seg_enc = 7'h30;
            4'd4:    seg_enc = 7'h19;
            4'd5:    seg_enc = 7'h12;
            4'd6:    seg_enc = 7'h02;
            4'd7:    seg_enc = 7'h78;
            4'd8:    seg_enc = 7'h00;
            4'd9:    seg_enc = 7'h10;
            default: seg_enc = SegBlank;
        endcase
    endfunction

    always_comb begin
        accept     = i_DV && (i_digit <= 4'd9) && !i_clear;
        blank_all  = (state_q == StEmpty) || ((state_q == StOverflow) && phase_off_q);
        blank_tens = blank_all || (state_q == StOne);
        tens7      = {3'b000, tens_q};
        ones7      = {3'b000, ones_q};
        value_d    = (tens7 << 3) + (tens7 << 1) + ones7;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            blink_cnt_q <= 24'd0;
            phase_off_q <= 1'b0;
            seg_tens_q  <= SegBlank;
            seg_ones_q  <= SegBlank;
            value_q     <= 7'd0;
        end else begin
            if (i_clear) begin
                state_q     <= StEmpty;
                tens_q      <= 4'd0;
                ones_q      <= 4'd0;
                blink_cnt_q <= 24'd0;
                phase_off_q <= 1'b0;
            end else if (state_q == StOverflow) begin
                if (blink_cnt_q == BlinkLast) begin
                    blink_cnt_q <= 24'd0;
                    phase_off_q <= ~phase_off_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 24'd1;
                end
            end else if (accept) begin
                case (state_q)
                    StEmpty: begin
                        state_q <= StOne;
                        ones_q  <= i_digit;
                    end
                    StOne: begin
                        // A leading zero is replaced rather than shifted into tens
                        if (ones_q != 4'd0) begin
                            state_q <= StTwo;
                            tens_q  <= ones_q;
                        end
                        ones_q <= i_digit;
                    end
                    default: begin
                        state_q     <= StOverflow;
                        blink_cnt_q <= 24'd0;
                        phase_off_q <= 1'b0;
                    end
                endcase
            end
            // Display follows the state one cycle later
            seg_tens_q <= blank_tens ? SegBlank : seg_enc(tens_q);
            seg_ones_q <= blank_all ? SegBlank : seg_enc(ones_q);
            value_q    <= value_d;
        end
    end

    always_comb begin
        case (state_q)
            StEmpty: o_count = 2'd0;
            StOne:   o_count = 2'd1;
            default: o_count = 2'd2;
        endcase
    end

    assign o_overflow = (state_q == StOverflow);
    assign o_seg_tens = seg_tens_q;
    assign o_seg_ones = seg_ones_q;
    assign o_value    = value_q;

endmodule
